// File: rtl/tick_scheduler.sv
// Programmable divide-by-N timebase: free-run or burst ticks, a divided square wave and a done pulse.
// Tick, clock_out and done are registered; cfg_ready and busy decode the state register directly.
module tick_scheduler #(
    parameter int unsigned      WIDTH           = 28,
    parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = 28'd5000000,
    parameter int unsigned      COUNT_W         = 8
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               cfg_valid,
    input  logic [WIDTH-1:0]   cfg_divisor,
    output logic               cfg_ready,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [COUNT_W-1:0] burst_len,
    output logic               tick,
    output logic               clock_out,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               clk_q, clk_d;
    logic               done_q, done_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] count_inc;
    logic               mode_q, mode_d;
    logic [COUNT_W-1:0] burst_q, burst_d;
    logic               start_ok;
    logic               tick_due;

    assign start_ok  = (state_q == S_IDLE) && start && !stop;
    assign tick_due  = (cnt_q == div_q - WIDTH'(1));
    assign count_inc = count_q + COUNT_W'(1);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= DEFAULT_DIVISOR;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            clk_q   <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            mode_q  <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
            done_q  <= done_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
        end
    end

    // A zero-length burst skips RUN entirely so no tick is ever issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (mode && (burst_len == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick_due && mode_q && (count_inc == burst_q)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready  = (state_q == S_IDLE);
        busy       = (state_q == S_RUN);
        tick       = tick_q;
        clock_out  = clk_q;
        done       = done_q;
        tick_count = count_q;
    end

    // Divisors of 0 and 1 both mean "tick every cycle".
    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        clk_d   = 1'b0;
        done_d  = (state_q == S_DONE);
        count_d = count_q;
        mode_d  = mode_q;
        burst_d = burst_q;
        if (cfg_valid && cfg_ready) begin
            div_d = (cfg_divisor > WIDTH'(1)) ? cfg_divisor : WIDTH'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    cnt_d   = '0;
                    count_d = '0;
                    mode_d  = mode;
                    burst_d = burst_len;
                end
            end
            S_RUN: begin
                if (stop) begin
                    cnt_d = '0;
                end else begin
                    clk_d = (cnt_q < (div_q >> 1));
                    if (tick_due) begin
                        cnt_d   = '0;
                        tick_d  = 1'b1;
                        count_d = count_inc;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: a hand-built vector table plus randomized runs against a timeline model.
module tb_tick_scheduler;

    localparam int W  = 28;
    localparam int CW = 8;

    logic          clock_in = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [W-1:0]  cfg_divisor;
    logic          cfg_ready;
    logic          start;
    logic          stop;
    logic          mode;
    logic [CW-1:0] burst_len;
    logic          tick;
    logic          clock_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] tick_count;

    int n_pass  = 0;
    int n_total = 0;
    int cur_div = 4;

    tick_scheduler #(.WIDTH(W), .DEFAULT_DIVISOR(28'd4), .COUNT_W(CW)) dut (
        .clock_in(clock_in), .reset(reset), .cfg_valid(cfg_valid), .cfg_divisor(cfg_divisor),
        .cfg_ready(cfg_ready), .start(start), .stop(stop), .mode(mode), .burst_len(burst_len),
        .tick(tick), .clock_out(clock_out), .busy(busy), .done(done), .tick_count(tick_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic          cv;
        logic [W-1:0]  cd;
        logic          st;
        logic          sp;
        logic          md;
        logic [CW-1:0] bl;
        logic          e_tick;
        logic          e_clk;
        logic          e_busy;
        logic          e_done;
        logic [CW-1:0] e_cnt;
        logic          e_rdy;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic cv, input int cd, input logic st, input logic sp,
                                input logic md, input int bl, input logic t, input logic c,
                                input logic b, input logic d, input int n, input logic r);
        vec_t v;
        v.cv = cv; v.cd = W'(cd); v.st = st; v.sp = sp; v.md = md; v.bl = CW'(bl);
        v.e_tick = t; v.e_clk = c; v.e_busy = b; v.e_done = d; v.e_cnt = CW'(n); v.e_rdy = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic t, input logic c, input logic b,
                              input logic d, input logic [CW-1:0] n, input logic r);
        chk({tag, " tick"}, 32'(tick), 32'(t));
        chk({tag, " clock_out"}, 32'(clock_out), 32'(c));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(d));
        chk({tag, " tick_count"}, 32'(tick_count), 32'(n));
        chk({tag, " cfg_ready"}, 32'(cfg_ready), 32'(r));
    endtask

    // Expected outputs in cycle k after a start edge, from the tick timeline: tick edges are multiples
    // of D, a burst ends on edge L*D, a stop on edge s freezes the count at the ticks before it.
    task automatic model_exp(input int D, input bit m, input int L, input int s_eff, input int k,
                             output logic t, output logic c, output logic b, output logic d,
                             output logic [CW-1:0] n, output logic r);
        int e;
        int tend;
        e = k - 1;
        tend = m ? L * D : (1 << 30);
        t = 0; c = 0; b = 0; d = 0; n = '0; r = 1;
        if (m && L == 0) begin
            r = (e != 0);
            d = (e == 1);
        end else if (s_eff != 0 && e >= s_eff) begin
            n = CW'((s_eff - 1) / D);
        end else if (e <= tend) begin
            b = (e < tend);
            r = 0;
            t = (e >= 1) && (e % D == 0);
            c = (e >= 1) && (((e - 1) % D) < D / 2);
            n = CW'(e / D);
        end else begin
            n = CW'(L);
            d = (e == tend + 1);
        end
    endtask

    // Call at a negedge with the DUT idle; starts a run on the next edge and checks ncyc cycles.
    task automatic run_model(input bit do_cfg, input int cd, input bit m, input int L,
                             input int s, input int ncyc, input bit rand_cfg, input string tag);
        int D;
        int tend;
        int s_eff;
        logic t, c, b, d, r;
        logic [CW-1:0] n;
        if (do_cfg) cur_div = (cd > 1) ? cd : 1;
        D = cur_div;
        tend = m ? L * D : (1 << 30);
        s_eff = (s >= 1 && s <= tend && !(m && L == 0)) ? s : 0;
        cfg_valid = do_cfg; cfg_divisor = W'(cd); start = 1; stop = 0; mode = m; burst_len = CW'(L);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock_in);
            start = 0;
            model_exp(D, m, L, s_eff, k, t, c, b, d, n, r);
            check_outs($sformatf("%s c%0d", tag, k), t, c, b, d, n, r);
            stop = (k == s);
            cfg_valid = rand_cfg && b && ($urandom_range(0, 1) == 1);
            cfg_divisor = W'($urandom_range(0, 9));
        end
        stop = 0; cfg_valid = 0;
    endtask

    initial begin
        int dd, cd, L, s, nc;
        bit dc, m;

        reset = 1; cfg_valid = 0; cfg_divisor = '0; start = 0; stop = 0; mode = 0; burst_len = '0;
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 1);
        @(negedge clock_in);
        @(negedge clock_in);
        reset = 0;

        // Default divisor 4, free-run: ticks in cycles 5/9/13, clock_out 1100.
        run_model(0, 0, 0, 0, 14, 16, 0, "default");

        tbl[0]  = mk(1, 3, 1, 0, 1, 2,  0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 7, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 2, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1);
        tbl[9]  = mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 2, 1);
        tbl[10] = mk(0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0);
        tbl[16] = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 18; i++) begin
            cfg_valid = tbl[i].cv; cfg_divisor = tbl[i].cd; start = tbl[i].st;
            stop = tbl[i].sp; mode = tbl[i].md; burst_len = tbl[i].bl;
            @(negedge clock_in);
            check_outs($sformatf("tbl%0d", i), tbl[i].e_tick, tbl[i].e_clk, tbl[i].e_busy,
                       tbl[i].e_done, tbl[i].e_cnt, tbl[i].e_rdy);
        end
        cfg_valid = 0; start = 0; stop = 0;
        cur_div = 3;

        for (int r = 0; r < 25; r++) begin
            dc = ($urandom_range(0, 1) == 1);
            cd = $urandom_range(0, 6);
            m  = ($urandom_range(0, 1) == 1);
            L  = $urandom_range(0, 5);
            dd = dc ? ((cd > 1) ? cd : 1) : cur_div;
            if (m) begin
                s  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, L * dd + 3) : 0;
                nc = ((s >= 1 && s <= L * dd) ? s : L * dd + 1) + 2;
            end else begin
                s  = $urandom_range(1, 20);
                nc = s + 2;
            end
            run_model(dc, cd, m, L, s, nc, 1, $sformatf("rnd%0d", r));
        end

        // Divisor 0 stored as 1: tick every cycle, count wraps after 256 ticks.
        run_model(1, 0, 0, 0, 259, 261, 0, "wrap");

        run_model(1, 2, 1, 5, 0, 6, 0, "preburst");
        #2 reset = 1;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, 0, 1);
        @(negedge clock_in);
        reset = 0;
        cur_div = 4;
        run_model(0, 0, 0, 0, 10, 12, 0, "postreset");
        run_model(0, 0, 1, 0, 0, 3, 0, "zeroburst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Programmable timebase controller that sequences a divide-by-N counter: it holds a runtime-configurable divisor, starts and stops the count, and emits single-cycle tick enables plus a divided square wave. It runs in free-run mode or one-shot burst mode; burst mode stops after a programmed number of ticks and pulses `done`. Downstream lab logic (display scan, LED blink, game step) uses `tick` as a clock enable instead of a derived clock.

## Interface
- `WIDTH`, 28, width of divisor and phase counter.
- `DEFAULT_DIVISOR`, 28'd5000000, divisor value loaded at reset.
- `COUNT_W`, 8, width of burst length and tick counter.

- `clock_in` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: divisor update request.
- `cfg_divisor` in WIDTH: requested divisor.
- `cfg_ready` out 1: divisor can be accepted (combinational, high in IDLE only).
- `start` in 1: begin counting (sampled in IDLE only).
- `stop` in 1: abort run.
- `mode` in 1: 0 = free-run, 1 = one-shot burst; latched at start.
- `burst_len` in COUNT_W: ticks per burst; latched at start.
- `tick` out 1: registered single-cycle enable, one every `div_q` cycles.
- `clock_out` out 1: registered divided square wave.
- `busy` out 1: state is RUN.
- `done` out 1: registered single-cycle pulse at burst completion.
- `tick_count` out COUNT_W: ticks issued since last start.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: `tick`=0, `clock_out`=0, `busy`=0, `done`=0, `tick_count`=0, `cfg_ready`=1, internal `div_q`=DEFAULT_DIVISOR, phase `cnt`=0.
- Config: on an edge with `cfg_valid && cfg_ready`, `div_q` <= `cfg_divisor`. Values 0 and 1 are both stored as 1. Outside IDLE, `cfg_valid` is ignored and no handshake completes.
- IDLE: `start` → RUN; `cnt`<=0, `tick_count`<=0, latch `mode`/`burst_len`. A config accepted on the same edge applies to that run. With `start && stop` on the same edge, `stop` wins and the state stays IDLE.
- IDLE, `mode`=1, `burst_len`=0: `start` → DONE directly; no ticks are issued.
- RUN, each edge, if `stop` is low:
  - `cnt == div_q-1`: `cnt`<=0, `tick`<=1, `tick_count`<=`tick_count`+1 (wraps modulo 2^COUNT_W).
  - Otherwise: `cnt`<=`cnt`+1, `tick`<=0.
- RUN, `mode`=1: the edge that issues tick number `burst_len` also moves to DONE.
- RUN, `stop` high: → IDLE; `cnt`<=0, `tick`<=0, `clock_out`<=0. Any tick due on that edge is suppressed. No `done` pulse. `tick_count` holds.
- `start` during RUN or DONE: ignored.
- DONE: `done`=1 for exactly one cycle, `busy`=0, then → IDLE unconditionally. `stop` in DONE has no effect.
- `clock_out` <= (state==RUN) && (`cnt` < `div_q`>>1), where `cnt` is the pre-edge value. With `div_q`=1, `clock_out` stays 0.
- Arithmetic: `cnt` is WIDTH bits; compares are unsigned; `div_q-1` never underflows because `div_q` ≥ 1.

## Timing
- Start sampled at edge E0 → `busy` high after E0. The first `tick` is high in the cycle after edge E0+`div_q`; subsequent ticks follow every `div_q` cycles.
- Burst of L ticks: the last tick and the DONE entry happen on the same edge. `tick` and `done` are therefore never high in the same cycle; `done` follows in the cycle after the last `tick`'s cycle.
- `cfg_ready` falls in the cycle after the start edge and rises again in the cycle after return to IDLE.
- Asynchronous `reset` mid-run: all outputs drop to reset values immediately. `div_q` also returns to DEFAULT_DIVISOR.

## Test plan
- Reset with DEFAULT_DIVISOR=4, `start`, `mode`=0 → `tick` pulses in cycles 5, 9, 13 after the start edge; `clock_out` pattern 1100 repeating; `tick_count` = 1, 2, 3.
- IDLE: `cfg_divisor`=3 with `cfg_valid`, `mode`=1, `burst_len`=2, `start` → ticks at cycles 4 and 7, `done` at cycle 8, `busy` low from cycle 8, `tick_count`=2 holds.
- `cfg_divisor`=0, free-run → `tick` high every cycle from cycle 2, `clock_out` stays 0; after 255 ticks, the next tick makes `tick_count` wrap to 0.
- RUN with divisor 4, assert `stop` on the edge a tick is due → no tick, no `done`, IDLE, `cfg_ready`=1, `tick_count` unchanged.
- `cfg_valid` during RUN → `cfg_ready`=0, divisor unchanged (tick spacing stays 4). `start` and `stop` together in IDLE → stays IDLE.
- Assert `reset` mid-burst → outputs 0 at once, `cfg_ready`=1; after release, free-run start uses DEFAULT_DIVISOR; `mode`=1 with `burst_len`=0 → `done` one cycle later, no ticks.
